cam_search_engine: RTL and testbench

Parametrised ternary CAM with per-entry valid bits and per-entry don't-care masks. It is the next generation of the row-array CAM. It adds an encoded write port, a 2-stage pipelined search with valid/ready handshake, priority-encoded match index, a multi-hit flag and a sequential flush FSM. It sits between the lookup client (packet or tag logic) and the table-maintenance controller.

---
 rtl/cam_search_engine.sv | 148 ++++++++++++++
 tb/tb_cam_search_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_search_engine.sv
// Ternary CAM with per-entry valid/mask, 2-stage pipelined search, priority-encoded result and flush FSM.
// Optional `CAM_FREE_SLOT_EN adds free_valid/free_index/full outputs derived from the valid bits.
module cam_search_engine #(
    parameter int CAM_WIDTH  = 8,
    parameter int CAM_DEPTH  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_inval,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [CAM_WIDTH-1:0]  wr_key,
    input  logic [CAM_WIDTH-1:0]  wr_mask,
    input  logic                  srch_valid,
    output logic                  srch_ready,
    input  logic [CAM_WIDTH-1:0]  srch_key,
    input  logic [CAM_WIDTH-1:0]  srch_mask,
    input  logic                  flush_req,
    output logic                  busy,
    output logic                  rslt_valid,
    output logic                  rslt_hit,
    output logic [ADDR_WIDTH-1:0] rslt_index,
    output logic                  rslt_multi,
    output logic [CAM_DEPTH-1:0]  rslt_vec
`ifdef CAM_FREE_SLOT_EN
    ,
    output logic                  free_valid,
    output logic [ADDR_WIDTH-1:0] free_index,
    output logic                  full
`endif
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_FLUSH = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(CAM_DEPTH - 1);

    logic [CAM_WIDTH-1:0]  key_mem  [CAM_DEPTH];
    logic [CAM_WIDTH-1:0]  mask_mem [CAM_DEPTH];
    logic [CAM_DEPTH-1:0]  valid;
    logic                  state;
    logic [ADDR_WIDTH-1:0] flush_cnt;

    logic                  accept;
    logic                  wr_ok;
    logic [CAM_DEPTH-1:0]  match_vec;
    logic                  s1_valid;
    logic [CAM_DEPTH-1:0]  s1_vec;
    logic [ADDR_WIDTH-1:0] enc_index;
    logic                  enc_multi;

    assign busy       = (state == ST_FLUSH);
    assign srch_ready = ~busy;
    assign accept     = srch_valid & srch_ready;
    // A flush request in the same idle cycle wins over a write.
    assign wr_ok      = wr_en & (state == ST_IDLE) & ~flush_req;

    // NOTE: always_comb uses blocking assignments and a default first, so no latch is inferred.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            match_vec[i] = valid[i] &
                           ~|((key_mem[i] ^ srch_key) & ~mask_mem[i] & ~srch_mask);
        end
    end

    // NOTE: key/mask storage is deliberately not reset; the valid bit alone qualifies an entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CAM_DEPTH; i++) begin
            if (wr_ok && !wr_inval && wr_addr == ADDR_WIDTH'(i)) begin
                key_mem[i]  <= wr_key;
                mask_mem[i] <= wr_mask;
            end
        end
    end

    // Out-of-range write addresses never equal any entry index and so fall through.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_req) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt + ADDR_WIDTH'(1);
                    if (flush_cnt == LAST_IDX) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            for (int i = 0; i < CAM_DEPTH; i++) begin
                if (state == ST_FLUSH && flush_cnt == ADDR_WIDTH'(i))
                    valid[i] <= 1'b0;
                else if (wr_ok && wr_addr == ADDR_WIDTH'(i))
                    valid[i] <= ~wr_inval;
            end
        end
    end

    always_comb begin
        enc_index = '0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (s1_vec[i]) enc_index = ADDR_WIDTH'(i);
        end
        enc_multi = |(s1_vec & (s1_vec - CAM_DEPTH'(1)));
    end

    // Stage 1 captures the match vector; stage 2 captures the encoded result.
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_vec     <= '0;
            rslt_valid <= 1'b0;
            rslt_hit   <= 1'b0;
            rslt_index <= '0;
            rslt_multi <= 1'b0;
            rslt_vec   <= '0;
        end else begin
            s1_valid   <= accept;
            s1_vec     <= accept ? match_vec : '0;
            rslt_valid <= s1_valid;
            rslt_hit   <= |s1_vec;
            rslt_index <= enc_index;
            rslt_multi <= enc_multi;
            rslt_vec   <= s1_vec;
        end
    end

`ifdef CAM_FREE_SLOT_EN
    always_comb begin
        free_index = '0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) free_index = ADDR_WIDTH'(i);
        end
    end

    assign full       = &valid;
    assign free_valid = ~full;
`endif

endmodule

// File: tb/tb_cam_search_engine.sv
// Self-checking bench for cam_search_engine: directed scenarios plus randomized traffic
// compared against a cycle-numbered behavioural table model.
module tb_cam_search_engine;

    localparam int W = 8;
    localparam int D = 8;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0, wr_inval = 1'b0;
    logic [A-1:0] wr_addr = '0;
    logic [W-1:0] wr_key = '0, wr_mask = '0;
    logic         srch_valid = 1'b0, srch_ready;
    logic [W-1:0] srch_key = '0, srch_mask = '0;
    logic         flush_req = 1'b0, busy;
    logic         rslt_valid, rslt_hit, rslt_multi;
    logic [A-1:0] rslt_index;
    logic [D-1:0] rslt_vec;

    always #5 clk = ~clk;

    cam_search_engine #(.CAM_WIDTH(W), .CAM_DEPTH(D), .ADDR_WIDTH(A)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_inval(wr_inval), .wr_addr(wr_addr),
        .wr_key(wr_key), .wr_mask(wr_mask),
        .srch_valid(srch_valid), .srch_ready(srch_ready),
        .srch_key(srch_key), .srch_mask(srch_mask),
        .flush_req(flush_req), .busy(busy),
        .rslt_valid(rslt_valid), .rslt_hit(rslt_hit), .rslt_index(rslt_index),
        .rslt_multi(rslt_multi), .rslt_vec(rslt_vec)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    // Reference model: table contents, flush window by cycle number, queue of due results.
    typedef struct {
        int           due;
        logic [D-1:0] vec;
    } exp_t;

    bit           m_init = 0;
    bit           m_busy = 0;
    int           cyc = 0;
    int           fl_start = 0;
    bit [D-1:0]   m_valid = '0;
    logic [W-1:0] m_key  [D];
    logic [W-1:0] m_mask [D];
    exp_t         exp_q[$];

    function automatic logic [D-1:0] model_match(input logic [W-1:0] k, input logic [W-1:0] m);
        logic [D-1:0] v = '0;
        for (int i = 0; i < D; i++)
            if (m_valid[i] && (((m_key[i] ^ k) & ~m_mask[i] & ~m) == '0)) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int lowest_set(input logic [D-1:0] v);
        for (int i = 0; i < D; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_init  = 1;
            m_valid = '0;
            m_busy  = 0;
            exp_q.delete();
        end else begin
            if (srch_valid && !m_busy) exp_q.push_back('{cyc + 1, model_match(srch_key, srch_mask)});
            if (m_busy) begin
                m_valid[cyc - fl_start - 1] = 1'b0;
                if (cyc - fl_start == D) m_busy = 0;
            end else if (flush_req) begin
                fl_start = cyc;
                m_busy   = 1;
            end else if (wr_en && int'(wr_addr) < D) begin
                m_valid[wr_addr] = !wr_inval;
                if (!wr_inval) begin
                    m_key[wr_addr]  = wr_key;
                    m_mask[wr_addr] = wr_mask;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("busy", busy, m_busy);
            check("srch_ready", srch_ready, !m_busy);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("rslt_valid", rslt_valid, 1);
                check("rslt_vec", rslt_vec, exp_q[0].vec);
                check("rslt_hit", rslt_hit, exp_q[0].vec != '0);
                check("rslt_index", rslt_index, lowest_set(exp_q[0].vec));
                check("rslt_multi", rslt_multi, $countones(exp_q[0].vec) > 1);
                void'(exp_q.pop_front());
            end else begin
                check("rslt_idle", rslt_valid, 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write(input logic [A-1:0] a, input logic [W-1:0] k, input logic [W-1:0] m);
        wr_en = 1; wr_inval = 0; wr_addr = a; wr_key = k; wr_mask = m;
        tick();
        wr_en = 0;
    endtask

    // Leaves the bench at the negedge where the result is visible.
    task automatic search(input logic [W-1:0] k, input logic [W-1:0] m);
        srch_valid = 1; srch_key = k; srch_mask = m;
        tick();
        srch_valid = 0;
        tick();
    endtask

    int busy_cnt;
    int nready_cnt;

    initial begin
        tick(); tick();
        rst = 0;
        tick();
        check("reset_busy", busy, 0);
        check("reset_ready", srch_ready, 1);
        check("reset_rslt_valid", rslt_valid, 0);
        check("reset_rslt_vec", rslt_vec, 0);

        write(3'd2, 8'hA5, 8'h00);
        search(8'hA5, 8'h00);
        check("single_valid", rslt_valid, 1);
        check("single_hit", rslt_hit, 1);
        check("single_index", rslt_index, 2);
        check("single_multi", rslt_multi, 0);
        check("single_vec", rslt_vec, 8'h04);

        write(3'd1, 8'hA0, 8'h0F);
        write(3'd5, 8'hA5, 8'h00);
        search(8'hA5, 8'h00);
        check("multi_hit", rslt_hit, 1);
        check("multi_index", rslt_index, 1);
        check("multi_multi", rslt_multi, 1);
        check("multi_vec", rslt_vec, 8'h26);

        search(8'h5A, 8'h00);
        check("miss_hit", rslt_hit, 0);
        check("miss_index", rslt_index, 0);
        check("miss_vec", rslt_vec, 8'h00);
        search(8'h5A, 8'hFF);
        check("allmask_vec", rslt_vec, 8'h26);

        // Back-to-back searches with a write at the second accept edge.
        srch_valid = 1; srch_key = 8'h3C; srch_mask = 8'h00;
        tick();
        wr_en = 1; wr_inval = 0; wr_addr = 3'd2; wr_key = 8'h3C; wr_mask = 8'h00;
        tick();
        check("b2b_1_valid", rslt_valid, 1);
        check("b2b_1_vec", rslt_vec, 8'h00);
        wr_en = 0;
        tick();
        check("b2b_2_valid", rslt_valid, 1);
        check("b2b_2_vec", rslt_vec, 8'h00);
        srch_valid = 0;
        tick();
        check("b2b_3_valid", rslt_valid, 1);
        check("b2b_3_vec", rslt_vec, 8'h04);

        // Flush colliding with a write, plus a second flush request mid-flush.
        flush_req = 1; wr_en = 1; wr_addr = 3'd3; wr_key = 8'h3C; wr_mask = 8'h00;
        tick();
        flush_req = 0; wr_en = 0;
        busy_cnt = 0;
        nready_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (busy) busy_cnt++;
            if (!srch_ready) nready_cnt++;
            flush_req  = (n == 3);
            srch_valid = (n == 4);
            srch_key   = 8'h3C;
            srch_mask  = 8'h00;
            tick();
        end
        flush_req = 0; srch_valid = 0;
        check("flush_busy_cycles", busy_cnt, 8);
        check("flush_nready_cycles", nready_cnt, 8);
        search(8'h3C, 8'h00);
        check("flush_drop_write_vec", rslt_vec, 8'h00);
        search(8'h00, 8'hFF);
        check("flush_all_clear_vec", rslt_vec, 8'h00);

        // Reset with a search in flight.
        write(3'd4, 8'h77, 8'h00);
        srch_valid = 1; srch_key = 8'h77; srch_mask = 8'h00;
        tick();
        srch_valid = 0;
        rst = 1;
        tick();
        check("rst_flight_rslt_valid", rslt_valid, 0);
        rst = 0;
        tick();
        check("rst_flight_rslt_valid2", rslt_valid, 0);
        search(8'h77, 8'h00);
        check("post_rst_valid", rslt_valid, 1);
        check("post_rst_hit", rslt_hit, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_inval   = ($urandom_range(0, 5) == 0);
            wr_addr    = A'($urandom_range(0, D - 1));
            wr_key     = 8'hA0 ^ 8'($urandom_range(0, 15));
            wr_mask    = 8'($urandom) & 8'($urandom) & 8'($urandom);
            srch_valid = $urandom_range(0, 1) == 1;
            srch_key   = 8'hA0 ^ 8'($urandom_range(0, 15));
            srch_mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
            flush_req  = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0; wr_en = 0; srch_valid = 0; flush_req = 0;
        for (int n = 0; n < 12; n++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
